// File: rtl/sonar_ranger.sv
// sonar_ranger: trigger/echo sequencer for the ultrasonic range sensor.
// Converts echo width to centimetres, with timeout and a recovery gap.
module sonar_ranger #(
  parameter int TRIG_CYCLES    = 500,
  parameter int CYC_PER_CM     = 2900,
  parameter int TIMEOUT_CYCLES = 1900000,
  parameter int RECOVER_CYCLES = 500000,
  parameter int DIST_W         = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trigger,
  input  logic              echo,
  output logic              sonar_trig,
  output logic              triggerSuc,
  output logic              valid,
  output logic [DIST_W-1:0] distance,
  output logic              timeout,
  output logic              busy
);

  localparam int MAX_A = (TIMEOUT_CYCLES > RECOVER_CYCLES) ?
                         TIMEOUT_CYCLES : RECOVER_CYCLES;
  localparam int MAX_C = (MAX_A > TRIG_CYCLES) ? MAX_A : TRIG_CYCLES;
  localparam int CW    = $clog2(MAX_C) + 1;
  localparam int PW    = $clog2(CYC_PER_CM) + 1;

  localparam logic [CW-1:0] TRIG_LAST = CW'(TRIG_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] REC_LAST  = CW'(RECOVER_CYCLES - 1);
  localparam logic [PW-1:0] PRE_LAST  = PW'(CYC_PER_CM - 1);
  localparam logic [DIST_W-1:0] D_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    RECOVER
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        sync_q;
  logic              echo_s;
  logic [PW-1:0]     pre_q, pre_d, base_pre, pre_n;
  logic [DIST_W-1:0] dist_q, dist_d, base_dist, dist_n;
  logic              fin, fin_tmo, suc_d;
  logic              valid_q, suc_q, tmo_q;
  logic [DIST_W-1:0] dist_out_q;

  assign echo_s = sync_q[1];

  // The rising-edge cycle in WAIT_RISE is echo cycle 1, stepped from zero.
  assign base_pre  = (state_q == MEASURE) ? pre_q  : '0;
  assign base_dist = (state_q == MEASURE) ? dist_q : '0;

  always_comb begin
    pre_n  = base_pre + 1'b1;
    dist_n = base_dist;
    if (base_pre == PRE_LAST) begin
      pre_n  = '0;
      dist_n = (base_dist == D_MAX) ? base_dist : base_dist + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    dist_d  = dist_q;
    fin     = 1'b0;
    fin_tmo = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (trigger) state_d = TRIG;
      end
      TRIG: begin
        if (cnt_q == TRIG_LAST) state_d = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (echo_s) begin
          state_d = MEASURE;
          pre_d   = pre_n;
          dist_d  = dist_n;
        end else if (cnt_q == TO_LAST) begin
          state_d = RECOVER;
          fin     = 1'b1;
          fin_tmo = 1'b1;
        end
      end
      MEASURE: begin
        if (!echo_s) begin
          state_d = RECOVER;
          fin     = 1'b1;
        end else if (cnt_q == TO_LAST) begin
          state_d = RECOVER;
          fin     = 1'b1;
          fin_tmo = 1'b1;
        end else begin
          pre_d  = pre_n;
          dist_d = dist_n;
        end
      end
      RECOVER: begin
        if (cnt_q == REC_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q || state_q == IDLE) cnt_d = '0;
    else cnt_d = cnt_q + 1'b1;
    suc_d = (state_d == TRIG) && (cnt_d == TRIG_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sync_q     <= '0;
      pre_q      <= '0;
      dist_q     <= '0;
      valid_q    <= 1'b0;
      suc_q      <= 1'b0;
      tmo_q      <= 1'b0;
      dist_out_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sync_q  <= {sync_q[0], echo};
      pre_q   <= pre_d;
      dist_q  <= dist_d;
      valid_q <= fin;
      suc_q   <= suc_d;
      if (fin) begin
        tmo_q      <= fin_tmo;
        dist_out_q <= fin_tmo ? D_MAX : dist_d;
      end
    end
  end

  assign sonar_trig = (state_q == TRIG);
  assign busy       = (state_q != IDLE);
  assign triggerSuc = suc_q;
  assign valid      = valid_q;
  assign distance   = dist_out_q;
  assign timeout    = tmo_q;

endmodule

// File: tb/tb_sonar_ranger.sv
// tb_sonar_ranger: directed checks of the sonar sequencer.
// Main DUT uses small sim parameters; a second DUT covers saturation.
module tb_sonar_ranger;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       trigger = 1'b0;
  logic       echo = 1'b0;
  logic       sonar_trig, triggerSuc, valid, timeout, busy;
  logic [8:0] distance;

  logic       trg2 = 1'b0;
  logic       echo2 = 1'b0;
  logic       strig2, suc2, val2, tmo2, busy2;
  logic [3:0] dist2;

  int n_chk = 0;
  int n_err = 0;

  int trig_hi, suc_n, suc_hi_at, v_n, both_n, lat, rec;
  logic suc_trig;
  logic [8:0] v_dist;
  logic v_tmo;

  always #5 clk = ~clk;

  sonar_ranger #(
    .TRIG_CYCLES(5), .CYC_PER_CM(4), .TIMEOUT_CYCLES(200),
    .RECOVER_CYCLES(10), .DIST_W(9)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .echo(echo),
    .sonar_trig(sonar_trig), .triggerSuc(triggerSuc), .valid(valid),
    .distance(distance), .timeout(timeout), .busy(busy)
  );

  sonar_ranger #(
    .TRIG_CYCLES(5), .CYC_PER_CM(1), .TIMEOUT_CYCLES(1000),
    .RECOVER_CYCLES(10), .DIST_W(4)
  ) u_sat (
    .clk(clk), .rst_n(rst_n), .trigger(trg2), .echo(echo2),
    .sonar_trig(strig2), .triggerSuc(suc2), .valid(val2),
    .distance(dist2), .timeout(tmo2), .busy(busy2)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // One full shot from IDLE until busy falls after valid.
  task automatic run_shot(input int dly, input int len, input bit poke);
    int c, sc, vc;
    bit done;
    c = 0; sc = -1; vc = -1; done = 0;
    trig_hi = 0; suc_n = 0; suc_hi_at = 0; v_n = 0; both_n = 0;
    rec = -1; suc_trig = 1'b0; v_dist = '0; v_tmo = 1'b0;
    trigger = 1'b1;
    while (!done && c < 2000) begin
      @(negedge clk);
      c++;
      trig_hi += int'(sonar_trig);
      if (triggerSuc) begin
        suc_n++; sc = c; suc_hi_at = trig_hi; suc_trig = sonar_trig;
      end
      if (valid) begin
        v_n++; vc = c; v_dist = distance; v_tmo = timeout;
        if (triggerSuc) both_n++;
      end
      if (vc >= 0 && !busy) begin
        rec = c - vc; done = 1;
      end
      trigger = poke && ((sc >= 0 && c == sc + 50) ||
                         (vc >= 0 && c == vc + 3));
      if (sc >= 0 && c == sc + dly) echo = 1'b1;
      if (sc >= 0 && len >= 0 && c == sc + dly + len) echo = 1'b0;
      if (vc >= 0) echo = 1'b0;
    end
    trigger = 1'b0;
    echo = 1'b0;
    if (!done) check("shot_bound", 0, 1);
    lat = vc - sc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    int k, qn;
    repeat (3) @(negedge clk);
    check("rst_trig", sonar_trig, 0);
    check("rst_suc", triggerSuc, 0);
    check("rst_valid", valid, 0);
    check("rst_tmo", timeout, 0);
    check("rst_busy", busy, 0);
    check("rst_dist", distance, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_shot(20, 103, 0);
    check("t1_trig_hi", trig_hi, 5);
    check("t1_suc_n", suc_n, 1);
    check("t1_suc_at", suc_hi_at, 5);
    check("t1_suc_trig", suc_trig, 1);
    check("t1_v_n", v_n, 1);
    check("t1_dist", v_dist, 25);
    check("t1_tmo", v_tmo, 0);
    check("t1_lat", lat, 126);
    check("t1_rec", rec, 10);
    check("t1_both", both_n, 0);
    check("t1_hold", distance, 25);

    run_shot(10000, -1, 0);
    check("t2_v_n", v_n, 1);
    check("t2_dist", v_dist, 511);
    check("t2_tmo", v_tmo, 1);
    check("t2_lat", lat, 201);
    check("t2_rec", rec, 10);

    run_shot(3, -1, 0);
    check("t3_v_n", v_n, 1);
    check("t3_dist", v_dist, 511);
    check("t3_tmo", v_tmo, 1);
    check("t3_lat", lat, 206);

    run_shot(20, 103, 1);
    check("t4_trig_hi", trig_hi, 5);
    check("t4_suc_n", suc_n, 1);
    check("t4_v_n", v_n, 1);
    check("t4_dist", v_dist, 25);
    check("t4_tmo", v_tmo, 0);
    qn = 0;
    repeat (5) begin
      @(negedge clk);
      qn += int'(sonar_trig) + int'(busy);
    end
    check("t4_idle", qn, 0);

    trg2 = 1'b1;
    @(negedge clk);
    trg2 = 1'b0;
    k = 0;
    while (!suc2 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) check("t5_suc_bound", 0, 1);
    echo2 = 1'b1;
    repeat (40) @(negedge clk);
    echo2 = 1'b0;
    k = 0;
    while (!val2 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("t5_valid", val2, 1);
    check("t5_dist", dist2, 15);
    check("t5_tmo", tmo2, 0);
    repeat (15) @(negedge clk);

    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    check("t6_trig_on", sonar_trig, 1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_trig_drop", sonar_trig, 0);
    check("t6_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    qn = 0;
    repeat (20) begin
      @(negedge clk);
      qn += int'(triggerSuc) + int'(valid) + int'(sonar_trig);
    end
    check("t6_quiet", qn, 0);
    check("t6_dist", distance, 0);
    run_shot(20, 103, 0);
    check("t6_trig_hi", trig_hi, 5);
    check("t6_suc_n", suc_n, 1);
    check("t6_dist2", v_dist, 25);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
